// File: rtl/fifo_umbral.sv
// Synchronous per-lane FIFO with loadable low/high occupancy thresholds.
// Build option FIFO_FLAG_REG_EN registers almost_empty/almost_full (one-cycle lag).
module fifo_umbral #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3,
    parameter int BAJO_RST   = 1,
    parameter int ALTO_RST   = 7
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [7:0]            umbral_bajo,
    input  logic [7:0]            umbral_alto,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, error_q;
    logic [7:0]            bajo_q, alto_q;
    logic                  empty, full, do_push, do_pop, ovf, udf;
    logic [7:0]            count8;
    logic                  ae_d, af_d;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    // When full, a concurrent pop frees the slot the push is about to reuse.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign ovf     = push && full && !pop;
    assign udf     = pop && empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            bajo_q   <= 8'(BAJO_RST);
            alto_q   <= 8'(ALTO_RST);
        end else begin
            if (init) begin
                bajo_q <= umbral_bajo;
                alto_q <= umbral_alto;
            end
            if (init)            error_q <= 1'b0;
            else if (ovf || udf) error_q <= 1'b1;
            if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
                data_q   <= mem_q[rd_ptr_q];
            end
            valid_q <= do_pop;
            count_q <= count_d;
        end
    end

    assign count8 = 8'(count_q);
    assign ae_d   = (count8 <= bajo_q);
    assign af_d   = (count8 >= alto_q);

`ifdef FIFO_FLAG_REG_EN
    logic ae_q, af_q;
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ae_q <= 1'b1;
            af_q <= 1'b0;
        end else begin
            ae_q <= ae_d;
            af_q <= af_d;
        end
    end
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
`else
    assign almost_empty = ae_d;
    assign almost_full  = af_d;
`endif

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign fifo_empty = empty;
    assign fifo_full  = full;
    assign fifo_error = error_q;
    assign count      = count_q;
endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Parameterised synchronous FIFO that sits at the far end of the link-control state machine. It accepts the low/high thresholds that the controller distributes during INIT and compares them against its own occupancy. It reports `fifo_empty` back into the controller's `empty_fifos` vector, and `almost_full`/`almost_empty` flow-control flags to the producer and consumer. One instance is placed per lane; eight instances feed the controller.

## Interface
- `DATA_WIDTH`, 10, payload width in bits.
- `ADDR_WIDTH`, 3, address width; depth is `DEPTH = 2**ADDR_WIDTH` (8).
- `BAJO_RST`, 1, low threshold value after reset.
- `ALTO_RST`, 7, high threshold value after reset.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset_L`, in, 1: asynchronous, active-low reset.
- `init`, in, 1: threshold load window; high means thresholds are sampled every cycle.
- `umbral_bajo`, in, 8: low threshold.
- `umbral_alto`, in, 8: high threshold.
- `push`, in, 1: write request.
- `data_in`, in, DATA_WIDTH: write data.
- `pop`, in, 1: read request.
- `data_out`, out, DATA_WIDTH: registered read data.
- `valid_out`, out, 1: `data_out` is valid this cycle.
- `fifo_empty`, out, 1: occupancy == 0.
- `fifo_full`, out, 1: occupancy == DEPTH.
- `almost_empty`, out, 1: occupancy <= low threshold.
- `almost_full`, out, 1: occupancy >= high threshold.
- `fifo_error`, out, 1: sticky overflow/underflow indication.
- `count`, out, ADDR_WIDTH+1: current occupancy.

## Operation
- Storage is a DEPTH-entry register array with write and read pointers, each ADDR_WIDTH bits, wrapping modulo DEPTH. `count` is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Threshold registers `bajo_q`/`alto_q`:
  - Loaded from `umbral_bajo`/`umbral_alto` on every edge where `init` = 1.
  - Hold their value otherwise.
  - Are never modified by push or pop.
- `init` = 1 also clears `fifo_error`. It does not flush contents or pointers.
- Flag comparison: `count` is zero-extended to 8 bits and compared unsigned.
  - `alto_q` > DEPTH means `almost_full` never asserts.
  - `bajo_q` >= DEPTH means `almost_empty` stays high at all times.
  - No ordering check is made between the two thresholds.
- Push when not full: write `data_in` at `wr_ptr`, then advance the pointer.
- Pop when not empty: register `mem[rd_ptr]` into `data_out`, advance the pointer, and set `valid_out` = 1 for the next cycle. Otherwise `valid_out` = 0 and `data_out` holds its last value.
- Simultaneous push and pop:
  - Not empty and not full: both execute and `count` is unchanged.
  - Full: both execute; the pop frees a slot and `count` stays DEPTH.
  - Empty: the push executes and the pop is an underflow, so `count` becomes 1.
- Overflow: push while full without pop. Data is dropped, pointers and `count` are unchanged, and `fifo_error` is set.
- Underflow: pop while empty. Nothing changes except `fifo_error`, which is set.
- `fifo_error` stays set until `reset_L` is low or `init` is high.

## Timing
- Reset (asynchronous, `reset_L` low) forces:
  - pointers, `count`, `data_out`, `valid_out`, `fifo_error` = 0;
  - `fifo_empty` = 1, `fifo_full` = 0;
  - `bajo_q` = BAJO_RST, `alto_q` = ALTO_RST;
  - `almost_empty` = 1, `almost_full` = 0.
- Memory contents are not reset.
- Reset asserted mid-burst discards all stored data immediately, without waiting for a clock edge.
- Release of reset is sampled synchronously; the first push is accepted on the first edge with `reset_L` high.
- Write latency: data pushed at edge N is poppable at edge N+1, and appears on `data_out` after that edge.
- Read latency: pop at edge N gives `data_out`/`valid_out` valid from N until edge N+1.
- `fifo_empty`, `fifo_full` and `count` are decoded from registered state and reflect edge N immediately after edge N.
- Thresholds loaded at edge N take effect on the flags immediately after edge N.

## Configuration
- `FIFO_FLAG_REG_EN`:
  - Defined: `almost_empty` and `almost_full` are registered. They lag `count` by exactly one cycle, and reset still yields `almost_empty` = 1, `almost_full` = 0.
  - Undefined: both flags are combinational from `count` and the threshold registers, with zero lag.
- `fifo_empty` and `fifo_full` are unaffected by this macro in both builds.

## Test plan
- Reset then 8 pushes of 0x001..0x008, then 8 pops: `data_out` is 0x001..0x008 in order, each with `valid_out` high, ending with `fifo_empty` = 1 and `count` = 0.
- `init` = 1 with `umbral_bajo` = 2, `umbral_alto` = 5, then 5 pushes: `almost_full` rises when `count` = 5 and `almost_empty` falls when `count` = 3. This rises one cycle later with `FIFO_FLAG_REG_EN`.
- Fill to 8, then push 0x3FF: `count` stays 8, `fifo_error` = 1, and subsequent pops return the original 8 words. A pulse of `init` clears the error.
- Empty FIFO with push 0x055 and pop in the same cycle: `count` = 1, `fifo_error` = 1, `valid_out` = 0, and the next pop returns 0x055.
- Full FIFO with push+pop held for 12 cycles: `count` stays 8, no error, and the pointers wrap so that output order equals input order.
- `reset_L` low asynchronously between clock edges at `count` = 4: all outputs take their reset values before the next edge, and `fifo_empty` = 1.
